// File: rtl/dbg_scan_pkg.sv
// dbg_scan_pkg: shared encodings for the dbg_scan_trace address sweeper.
// Holds the FSM state codes, sweep-mode constants and the FIFO entry width
// helper (2*XLEN by default, 3*XLEN when DBG_PC_STAMP_EN adds a PC field).
package dbg_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic MODE_RF  = 1'b0;
    localparam logic MODE_MEM = 1'b1;

    // Entry = {addr, data} or {addr, data, pc}.
    function automatic int entry_width(input int xlen, input bit pc_stamp);
        return pc_stamp ? 3 * xlen : 2 * xlen;
    endfunction

endpackage

// File: rtl/dbg_scan_trace_fifo.sv
// dbg_sync_fifo: first-word fall-through synchronous FIFO with flush.
// A push while full is accepted only together with a pop; the head reads 0
// while empty so the stream outputs are clean after reset or flush.
module dbg_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count; flush empties the queue and beats any push or pop.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: non-blocking assignments so all flops update together at the edge.
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q alone decides which slots are valid.
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dbg_scan_trace.sv
// dbg_scan_trace: sweeps a register-file or data-memory address range on the
// CPU debug ports, samples each value after HOLD settle cycles and queues
// {addr, data} into a FIFO drained over a valid/ready stream.
// Optional: define DBG_PC_STAMP_EN to add out_pc, storing wb_pc per sample.
module dbg_scan_trace
    import dbg_scan_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5,
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [XLEN-1:0]  first_addr,
    input  logic [XLEN-1:0]  last_addr,
    input  logic [XLEN-1:0]  stride,
    output logic [RF_AW-1:0] rf_addr,
    input  logic [XLEN-1:0]  rf_data,
    output logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [XLEN-1:0]  wb_pc,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_addr,
`ifdef DBG_PC_STAMP_EN
    output logic [XLEN-1:0]  out_pc,
`endif
    output logic [XLEN-1:0]  out_data
);
`ifdef DBG_PC_STAMP_EN
    localparam bit PC_STAMP = 1'b1;
`else
    localparam bit PC_STAMP = 1'b0;
`endif
    localparam int EW = entry_width(XLEN, PC_STAMP);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  cur_q, cur_d;
    logic [XLEN-1:0]  last_q, last_d;
    logic [XLEN-1:0]  stride_q, stride_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RF_AW-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;

    logic [XLEN:0]    next_sum;
    logic [XLEN-1:0]  sample_data;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full, can_accept;
    logic [EW-1:0]    fifo_din, fifo_dout;
    logic             drive_addr;

    assign next_sum    = {1'b0, cur_q} + {1'b0, stride_q};
    assign sample_data = (mode_q == MODE_MEM) ? mem_data : rf_data;
    assign fifo_pop    = !fifo_empty && out_ready;
    assign can_accept  = !fifo_full || fifo_pop;

`ifdef DBG_PC_STAMP_EN
    assign fifo_din = {cur_q, sample_data, wb_pc};
    assign out_pc   = fifo_dout[XLEN-1:0];
`else
    assign fifo_din = {cur_q, sample_data};
    logic unused_wb_pc;
    assign unused_wb_pc = ^wb_pc;
`endif

    // Sweep FSM plus the registered debug address it drives next cycle.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        stride_d  = stride_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    last_d   = last_addr;
                    stride_d = (stride == '0) ? XLEN'(1) : stride;
                    cur_d    = first_addr;
                    cnt_d    = CW'(HOLD - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_SAMPLE: begin
                // Stall here with the address held until the FIFO has room.
                if (can_accept) begin
                    fifo_push = 1'b1;
                    if ((cur_q >= last_q) || next_sum[XLEN]) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = next_sum[XLEN-1:0];
                        cnt_d   = CW'(HOLD - 1);
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            fifo_push = 1'b0;
        end

        drive_addr = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        rf_addr_d  = (drive_addr && mode_d == MODE_RF)  ? cur_d[RF_AW-1:0] : '0;
        mem_addr_d = (drive_addr && mode_d == MODE_MEM) ? cur_d            : '0;
    end

    // Sweep state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            stride_q   <= '0;
            mode_q     <= MODE_RF;
            cnt_q      <= '0;
            rf_addr_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            stride_q   <= stride_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            rf_addr_q  <= rf_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = !fifo_empty;
    assign out_addr  = fifo_dout[EW-1 -: XLEN];
    assign out_data  = fifo_dout[EW-XLEN-1 -: XLEN];

    dbg_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (abort),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule
